// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Control FSM for a shared-memory multicycle MIPS32 datapath (PC, IR, regfile,
// ALU, ALUOut). It decodes the same opcodes as the single-cycle decoder, drives
// the per-cycle enables and mux selects, and talks to a unified memory. It traps
// on an illegal opcode or a memory timeout, and counts retired instructions.
//
// Ports
//   i_clk, i_rst_n    clock (rising edge), asynchronous active-low reset
//   i_opcode[5:0]     IR[31:26], valid from DECODE onward
//   i_zero            ALU zero flag
//   i_mem_ready       memory finishes the pending read/write in this cycle
//   o_mem_read/write  memory request strobes
//   o_iord            address select: 0 PC, 1 ALUOut
//   o_ir_write        load IR from memory read data
//   o_pc_write        load PC
//   o_pc_src[1:0]     00 ALU result, 01 ALUOut, 10 jump target
//   o_alu_src_a       0 PC, 1 regA
//   o_alu_src_b[1:0]  00 regB, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//   o_alu_op[1:0]     00 add, 01 sub, 10 funct, 11 opcode (immediate ops)
//   o_reg_write       regfile write enable
//   o_reg_dst         0 rt, 1 rd
//   o_memto_reg       0 ALUOut, 1 MDR
//   o_trap            sticky fault flag
//   o_state[3:0]      current state encoding (debug)
//   o_retired         retired-instruction count, wraps
//
// Memory handshake: a request (o_mem_read or o_mem_write) stays asserted until
// the cycle in which i_mem_ready is high; that cycle completes the transfer.
// A request may wait at most MEM_TIMEOUT cycles: if the MEM_TIMEOUT-th
// consecutive cycle still sees i_mem_ready low, the FSM goes to TRAP. Ready in
// that same cycle still completes the transfer normally.
//
// Moore outputs are registered (decoded from the next state). o_ir_write and
// o_pc_write are Mealy: they depend on i_mem_ready / i_zero in the current cycle.
module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [5:0]       i_opcode,
    input  logic             i_zero,
    input  logic             i_mem_ready,
    output logic             o_mem_read,
    output logic             o_mem_write,
    output logic             o_iord,
    output logic             o_ir_write,
    output logic             o_pc_write,
    output logic [1:0]       o_pc_src,
    output logic             o_alu_src_a,
    output logic [1:0]       o_alu_src_b,
    output logic [1:0]       o_alu_op,
    output logic             o_reg_write,
    output logic             o_reg_dst,
    output logic             o_memto_reg,
    output logic             o_trap,
    output logic [3:0]       o_state,
    output logic [CNT_W-1:0] o_retired
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_IMMEX  = 4'd10,
        S_IMMWB  = 4'd11,
        S_JUMP   = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              is_bne;    // branch kind captured in DECODE
    logic              is_sw;     // load/store kind captured in DECODE
    logic              mem_busy;
    logic              timeout;
    logic              retire;

    assign mem_busy = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign timeout  = mem_busy && !i_mem_ready && (wait_cnt == WAIT_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   state_nxt = S_FETCH;
            S_FETCH: begin
                if (i_mem_ready)  state_nxt = S_DECODE;
                else if (timeout) state_nxt = S_TRAP;
            end
            S_DECODE: begin
                case (i_opcode)
                    OP_RTYPE:                                 state_nxt = S_EXEC;
                    OP_LW, OP_SW:                             state_nxt = S_MEMADR;
                    OP_BEQ, OP_BNE:                           state_nxt = S_BRANCH;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: state_nxt = S_IMMEX;
                    OP_J:                                     state_nxt = S_JUMP;
                    default:                                  state_nxt = S_TRAP;
                endcase
            end
            S_MEMADR: state_nxt = is_sw ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (i_mem_ready)  state_nxt = S_MEMWB;
                else if (timeout) state_nxt = S_TRAP;
            end
            S_MEMWB:  state_nxt = S_FETCH;
            S_MEMWR: begin
                if (i_mem_ready)  state_nxt = S_FETCH;
                else if (timeout) state_nxt = S_TRAP;
            end
            S_EXEC:   state_nxt = S_ALUWB;
            S_ALUWB:  state_nxt = S_FETCH;
            S_BRANCH: state_nxt = S_FETCH;
            S_IMMEX:  state_nxt = S_IMMWB;
            S_IMMWB:  state_nxt = S_FETCH;
            S_JUMP:   state_nxt = S_FETCH;
            S_TRAP:   state_nxt = S_TRAP;
            default:  state_nxt = S_TRAP;
        endcase
    end

    // An instruction retires when its last state hands back to FETCH.
    // IDLE->FETCH and FETCH holding in place do not count.
    assign retire = (state_nxt == S_FETCH) &&
                    ((state == S_MEMWB) || (state == S_MEMWR) || (state == S_ALUWB) ||
                     (state == S_BRANCH) || (state == S_IMMWB) || (state == S_JUMP));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            is_bne      <= 1'b0;
            is_sw       <= 1'b0;
            o_retired   <= '0;
            o_mem_read  <= 1'b0;
            o_mem_write <= 1'b0;
            o_iord      <= 1'b0;
            o_pc_src    <= 2'b00;
            o_alu_src_a <= 1'b0;
            o_alu_src_b <= 2'b00;
            o_alu_op    <= 2'b00;
            o_reg_write <= 1'b0;
            o_reg_dst   <= 1'b0;
            o_memto_reg <= 1'b0;
            o_trap      <= 1'b0;
        end else begin
            state <= state_nxt;

            // Counts consecutive unanswered cycles of one request; any
            // completion or state change starts the next request from zero.
            if (mem_busy && !i_mem_ready && (state_nxt == state))
                wait_cnt <= wait_cnt + WAIT_W'(1);
            else
                wait_cnt <= '0;

            if (state == S_DECODE) begin
                is_bne <= (i_opcode == OP_BNE);
                is_sw  <= (i_opcode == OP_SW);
            end

            if (retire)
                o_retired <= o_retired + CNT_W'(1);

            // Registered Moore outputs for the state being entered.
            o_mem_read  <= 1'b0;
            o_mem_write <= 1'b0;
            o_iord      <= 1'b0;
            o_pc_src    <= 2'b00;
            o_alu_src_a <= 1'b0;
            o_alu_src_b <= 2'b00;
            o_alu_op    <= 2'b00;
            o_reg_write <= 1'b0;
            o_reg_dst   <= 1'b0;
            o_memto_reg <= 1'b0;
            o_trap      <= 1'b0;
            case (state_nxt)
                S_FETCH: begin
                    o_mem_read  <= 1'b1;
                    o_alu_src_b <= 2'b01;
                end
                S_DECODE: o_alu_src_b <= 2'b11;
                S_MEMADR: begin
                    o_alu_src_a <= 1'b1;
                    o_alu_src_b <= 2'b10;
                end
                S_MEMRD: begin
                    o_mem_read <= 1'b1;
                    o_iord     <= 1'b1;
                end
                S_MEMWB: begin
                    o_reg_write <= 1'b1;
                    o_memto_reg <= 1'b1;
                end
                S_MEMWR: begin
                    o_mem_write <= 1'b1;
                    o_iord      <= 1'b1;
                end
                S_EXEC: begin
                    o_alu_src_a <= 1'b1;
                    o_alu_op    <= 2'b10;
                end
                S_ALUWB: begin
                    o_reg_write <= 1'b1;
                    o_reg_dst   <= 1'b1;
                end
                S_BRANCH: begin
                    o_alu_src_a <= 1'b1;
                    o_alu_op    <= 2'b01;
                    o_pc_src    <= 2'b01;
                end
                S_IMMEX: begin
                    o_alu_src_a <= 1'b1;
                    o_alu_src_b <= 2'b10;
                    o_alu_op    <= 2'b11;
                end
                S_IMMWB:  o_reg_write <= 1'b1;
                S_JUMP:   o_pc_src    <= 2'b10;
                S_TRAP:   o_trap      <= 1'b1;
                default: ;
            endcase
        end
    end

    // Mealy strobes, gated by the registered state so they are 0 in IDLE/TRAP.
    assign o_ir_write = (state == S_FETCH) && i_mem_ready;
    assign o_pc_write = o_ir_write ||
                        (state == S_JUMP) ||
                        ((state == S_BRANCH) && (is_bne ? !i_zero : i_zero));

    assign o_state = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl. The reference model expands each instruction
// (class, zero flag, fetch/memory wait lengths) into its expected per-cycle
// trace of control outputs and retired count; the driver replays the trace.
module tb_mips_multicycle_ctrl;

    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_W       = 8;

    logic             i_clk;
    logic             i_rst_n;
    logic [5:0]       i_opcode;
    logic             i_zero;
    logic             i_mem_ready;
    logic             o_mem_read, o_mem_write, o_iord, o_ir_write, o_pc_write;
    logic [1:0]       o_pc_src;
    logic             o_alu_src_a;
    logic [1:0]       o_alu_src_b;
    logic [1:0]       o_alu_op;
    logic             o_reg_write, o_reg_dst, o_memto_reg, o_trap;
    logic [3:0]       o_state;
    logic [CNT_W-1:0] o_retired;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_opcode(i_opcode), .i_zero(i_zero),
        .i_mem_ready(i_mem_ready), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .o_iord(o_iord), .o_ir_write(o_ir_write), .o_pc_write(o_pc_write),
        .o_pc_src(o_pc_src), .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b),
        .o_alu_op(o_alu_op), .o_reg_write(o_reg_write), .o_reg_dst(o_reg_dst),
        .o_memto_reg(o_memto_reg), .o_trap(o_trap), .o_state(o_state),
        .o_retired(o_retired)
    );

    // ---------------- clock ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic [19:0] act_ctl;
    assign act_ctl = {o_state, o_mem_read, o_mem_write, o_iord, o_ir_write, o_pc_write,
                      o_pc_src, o_alu_src_a, o_alu_src_b, o_alu_op,
                      o_reg_write, o_reg_dst, o_memto_reg, o_trap};

    // ---------------- scoreboard ----------------
    typedef struct {
        logic             ready;
        logic [5:0]       opcode;
        logic             zero;
        logic [19:0]      ctl;
        logic [CNT_W-1:0] ret;
        string            tag;
    } cyc_t;

    cyc_t             exp_q[$];
    logic [CNT_W-1:0] m_retired;
    bit               m_trap;
    int               n_checks = 0;
    int               n_pass   = 0;

    logic [5:0] legal_ops [11] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05,
                                   6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h02};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [5:0] rnd_op();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Control signal bundle, in act_ctl order below the state field.
    function automatic logic [15:0] sig(int mr, int mw, int iord, int irw, int pcw, int pcsrc,
                                        int sa, int sb, int op, int rw, int rd, int m2r, int tr);
        return {mr[0], mw[0], iord[0], irw[0], pcw[0], pcsrc[1:0], sa[0], sb[1:0], op[1:0],
                rw[0], rd[0], m2r[0], tr[0]};
    endfunction

    task automatic push(input string tag, input int st, input logic [15:0] sg,
                        input logic rdy, input logic z, input logic [5:0] opc);
        cyc_t c;
        c.tag = tag; c.ready = rdy; c.zero = z; c.opcode = opc;
        c.ctl = {st[3:0], sg};
        c.ret = m_retired;
        exp_q.push_back(c);
    endtask

    task automatic plan_trap(input int n);
        for (int i = 0; i < n; i++)
            push("trap", 13, sig(0,0,0,0,0,0,0,0,0,0,0,0,1), rnd_bit(), rnd_bit(), rnd_op());
        m_trap = 1;
    endtask

    // A memory access: nwait unanswered cycles, then the completing cycle,
    // unless the wait reaches MEM_TIMEOUT, which ends in TRAP. Returns 1 if done.
    task automatic plan_mem(input string tag, input int st, input logic [15:0] sg_wait,
                            input logic [15:0] sg_done, input int nwait, output bit ok);
        int w;
        w = (nwait < MEM_TIMEOUT) ? nwait : MEM_TIMEOUT;
        for (int i = 0; i < w; i++) push(tag, st, sg_wait, 1'b0, rnd_bit(), rnd_op());
        if (nwait >= MEM_TIMEOUT) begin
            plan_trap(20);
            ok = 0;
        end else begin
            push(tag, st, sg_done, 1'b1, rnd_bit(), rnd_op());
            ok = 1;
        end
    endtask

    task automatic plan_instr(input logic [5:0] opc, input logic z, input int fwait, input int mwait);
        bit ok;
        plan_mem("fetch", 1, sig(1,0,0,0,0,0,0,1,0,0,0,0,0), sig(1,0,0,1,1,0,0,1,0,0,0,0,0),
                 fwait, ok);
        if (!ok) return;
        push("decode", 2, sig(0,0,0,0,0,0,0,3,0,0,0,0,0), rnd_bit(), rnd_bit(), opc);
        case (opc)
            6'h00: begin
                push("exec",  7, sig(0,0,0,0,0,0,1,0,2,0,0,0,0), rnd_bit(), rnd_bit(), rnd_op());
                push("aluwb", 8, sig(0,0,0,0,0,0,0,0,0,1,1,0,0), rnd_bit(), rnd_bit(), rnd_op());
            end
            6'h23: begin
                push("memadr", 3, sig(0,0,0,0,0,0,1,2,0,0,0,0,0), rnd_bit(), rnd_bit(), rnd_op());
                plan_mem("memrd", 4, sig(1,0,1,0,0,0,0,0,0,0,0,0,0),
                         sig(1,0,1,0,0,0,0,0,0,0,0,0,0), mwait, ok);
                if (!ok) return;
                push("memwb", 5, sig(0,0,0,0,0,0,0,0,0,1,0,1,0), rnd_bit(), rnd_bit(), rnd_op());
            end
            6'h2B: begin
                push("memadr", 3, sig(0,0,0,0,0,0,1,2,0,0,0,0,0), rnd_bit(), rnd_bit(), rnd_op());
                plan_mem("memwr", 6, sig(0,1,1,0,0,0,0,0,0,0,0,0,0),
                         sig(0,1,1,0,0,0,0,0,0,0,0,0,0), mwait, ok);
                if (!ok) return;
            end
            6'h04, 6'h05: begin
                int taken;
                taken = (opc == 6'h04) ? int'(z) : int'(!z);
                push("branch", 9, sig(0,0,0,0,taken,1,1,0,1,0,0,0,0), rnd_bit(), z, rnd_op());
            end
            6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E: begin
                push("immex", 10, sig(0,0,0,0,0,0,1,2,3,0,0,0,0), rnd_bit(), rnd_bit(), rnd_op());
                push("immwb", 11, sig(0,0,0,0,0,0,0,0,0,1,0,0,0), rnd_bit(), rnd_bit(), rnd_op());
            end
            6'h02: push("jump", 12, sig(0,0,0,0,1,2,0,0,0,0,0,0,0), rnd_bit(), rnd_bit(), rnd_op());
            default: begin
                plan_trap(20);
                return;
            end
        endcase
        m_retired = m_retired + 1'b1;
    endtask

    // ---------------- driver ----------------
    // Replays up to n planned cycles (all if n < 0); inputs change just after
    // the rising edge, outputs are sampled on the falling edge.
    task automatic run_q(input int n);
        cyc_t c;
        while (exp_q.size() > 0 && n != 0) begin
            c = exp_q.pop_front();
            @(posedge i_clk);
            #1;
            i_mem_ready = c.ready;
            i_opcode    = c.opcode;
            i_zero      = c.zero;
            @(negedge i_clk);
            check_eq(c.tag, 64'(act_ctl), 64'(c.ctl));
            check_eq({c.tag, "_retired"}, 64'(o_retired), 64'(c.ret));
            n--;
        end
    endtask

    // Asynchronous reset away from any clock edge; outputs must clear at once.
    task automatic do_reset();
        #2;
        i_rst_n = 1'b0;
        #1;
        check_eq("rst_ctl", 64'(act_ctl), 64'd0);
        check_eq("rst_retired", 64'(o_retired), 64'd0);
        exp_q.delete();
        m_retired = '0;
        m_trap    = 0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        check_eq("idle_ctl", 64'(act_ctl), 64'd0);
    endtask

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 39);
        if (r < 26) return 0;
        if (r < 38) return $urandom_range(1, 4);
        return $urandom_range(MEM_TIMEOUT - 2, MEM_TIMEOUT + 1);
    endfunction

    function automatic logic [5:0] pick_op();
        logic [5:0] op;
        bit legal;
        if ($urandom_range(0, 29) != 0) return legal_ops[$urandom_range(0, 10)];
        do begin
            op = rnd_op();
            legal = 0;
            foreach (legal_ops[i]) if (legal_ops[i] == op) legal = 1;
        end while (legal);
        return op;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        i_rst_n     = 1'b1;
        i_opcode    = '0;
        i_zero      = 1'b0;
        i_mem_ready = 1'b0;
        m_retired   = '0;
        m_trap      = 0;

        do_reset();

        // R-type, memory always ready: 1,2,7,8 then back to FETCH.
        plan_instr(6'h00, 1'b0, 0, 0);
        run_q(-1);
        // LW with three unanswered MEMRD cycles.
        plan_instr(6'h23, 1'b0, 0, 3);
        run_q(-1);
        // Branch resolution.
        plan_instr(6'h04, 1'b1, 0, 0);
        plan_instr(6'h05, 1'b1, 0, 0);
        plan_instr(6'h05, 1'b0, 0, 0);
        plan_instr(6'h04, 1'b0, 0, 0);
        plan_instr(6'h2B, 1'b0, 1, 2);
        plan_instr(6'h0D, 1'b0, 0, 0);
        plan_instr(6'h02, 1'b0, 0, 0);
        run_q(-1);

        // Illegal opcode, then 20 cycles in TRAP.
        plan_instr(6'h3F, 1'b0, 0, 0);
        run_q(-1);
        do_reset();

        // Fetch answered on the last allowed cycle.
        plan_instr(6'h00, 1'b0, MEM_TIMEOUT - 1, 0);
        run_q(-1);
        // Fetch never answered within the window.
        plan_instr(6'h00, 1'b0, MEM_TIMEOUT, 0);
        run_q(-1);
        do_reset();

        // Reset while a store is waiting in MEMWR.
        plan_instr(6'h08, 1'b0, 0, 0);
        plan_instr(6'h2B, 1'b0, 0, 10);
        run_q(8);
        do_reset();

        // Counter wrap: more than 2^CNT_W jumps.
        for (int k = 0; k < (1 << CNT_W) + 4; k++) begin
            plan_instr(6'h02, 1'b0, 0, 0);
            run_q(-1);
        end
        do_reset();

        // Randomized instruction stream.
        for (int k = 0; k < 300; k++) begin
            plan_instr(pick_op(), rnd_bit(), pick_wait(), pick_wait());
            run_q(-1);
            if (m_trap) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
